// File: rtl/switch_arbiter_if.sv
// Switch allocator port bundle for the five-port router.
// err_timeout exists only when SWITCH_ARB_HOLD_TIMEOUT_EN is defined.
interface switch_arbiter_if;
    logic [2:0] e_req, w_req, n_req, s_req, j_req;
    logic       e_vc_grant, w_vc_grant, n_vc_grant;
    logic       s_vc_grant, j_vc_grant;
    logic       e_tail, w_tail, n_tail, s_tail, j_tail;
    logic       e_credit, w_credit, n_credit;
    logic       s_credit, j_credit;
    logic       e_gnt, w_gnt, n_gnt, s_gnt, j_gnt;
    logic [2:0] sel_e, sel_w, sel_n, sel_s, sel_j;
    logic       alloc_e, alloc_w, alloc_n, alloc_s, alloc_j;
`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
    logic [4:0] err_timeout;
`endif

    modport master (
`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
        input  err_timeout,
`endif
        output e_req, w_req, n_req, s_req, j_req,
        output e_vc_grant, w_vc_grant, n_vc_grant,
        output s_vc_grant, j_vc_grant,
        output e_tail, w_tail, n_tail, s_tail, j_tail,
        output e_credit, w_credit, n_credit,
        output s_credit, j_credit,
        input  e_gnt, w_gnt, n_gnt, s_gnt, j_gnt,
        input  sel_e, sel_w, sel_n, sel_s, sel_j,
        input  alloc_e, alloc_w, alloc_n, alloc_s, alloc_j
    );

    modport slave (
`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
        output err_timeout,
`endif
        input  e_req, w_req, n_req, s_req, j_req,
        input  e_vc_grant, w_vc_grant, n_vc_grant,
        input  s_vc_grant, j_vc_grant,
        input  e_tail, w_tail, n_tail, s_tail, j_tail,
        input  e_credit, w_credit, n_credit,
        input  s_credit, j_credit,
        output e_gnt, w_gnt, n_gnt, s_gnt, j_gnt,
        output sel_e, sel_w, sel_n, sel_s, sel_j,
        output alloc_e, alloc_w, alloc_n, alloc_s, alloc_j
    );
endinterface

// File: rtl/switch_arbiter.sv
// Round-robin switch allocator, one locking arbiter per output port.
// Optional stall timeout: define SWITCH_ARB_HOLD_TIMEOUT_EN.
module switch_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic            clk,
    input  logic            reset,
    switch_arbiter_if.slave sw
);
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    if (!((1 << CNT_W) > HOLD_MAX)) begin : g_cfg_chk
        $error("switch_arbiter: CNT_W too small for HOLD_MAX");
    end

    logic [2:0] req [5];
    logic [7:0] vc_v;
    logic [7:0] tail_v;
    logic [4:0] credit;

    state_e     st_q  [5];
    state_e     st_d  [5];
    logic [2:0] own_q [5];
    logic [2:0] own_d [5];
    logic [2:0] ptr_q [5];
    logic [2:0] ptr_d [5];

    logic [4:0] found;
    logic [2:0] win [5];
    logic [4:0] xfer;
    logic [4:0] gnt;
    logic [2:0] sel [5];

`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HoldMaxC = CNT_W'(HOLD_MAX);
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic [4:0]       err_q;
    logic [4:0]       err_d;
`endif

    assign req[0] = sw.e_req;
    assign req[1] = sw.w_req;
    assign req[2] = sw.n_req;
    assign req[3] = sw.s_req;
    assign req[4] = sw.j_req;

    // Padded to 8 so a 3-bit owner index never leaves the vector.
    assign vc_v = {3'b000, sw.j_vc_grant, sw.s_vc_grant,
                   sw.n_vc_grant, sw.w_vc_grant, sw.e_vc_grant};
    assign tail_v = {3'b000, sw.j_tail, sw.s_tail,
                     sw.n_tail, sw.w_tail, sw.e_tail};
    assign credit = {sw.j_credit, sw.s_credit, sw.n_credit,
                     sw.w_credit, sw.e_credit};

    // Round-robin search per output, starting after the last winner.
    always_comb begin
        int         idx;
        logic [2:0] idx3;
        idx  = 0;
        idx3 = 3'd0;
        for (int o = 0; o < 5; o++) begin
            found[o] = 1'b0;
            win[o]   = 3'd0;
            for (int k = 1; k <= 5; k++) begin
                idx = int'(ptr_q[o]) + k;
                if (idx >= 5) begin
                    idx = idx - 5;
                end
                idx3 = 3'(idx);
                if (!found[o] && vc_v[idx3] &&
                    req[idx3] == 3'(o)) begin
                    found[o] = 1'b1;
                    win[o]   = idx3;
                end
            end
        end
    end

    // Transfer, grant and crossbar select from registered lock state.
    always_comb begin
        gnt = 5'b0;
        for (int o = 0; o < 5; o++) begin
            xfer[o] = (st_q[o] == LOCKED) &&
                      vc_v[own_q[o]] && credit[o];
            sel[o]  = (st_q[o] == LOCKED) ? own_q[o] : 3'd0;
            for (int i = 0; i < 5; i++) begin
                if (xfer[o] && own_q[o] == 3'(i)) begin
                    gnt[i] = 1'b1;
                end
            end
        end
    end

    // Per-output lock FSM: arbitrate in IDLE, release on tail.
    always_comb begin
`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
        err_d = 5'b0;
`endif
        for (int o = 0; o < 5; o++) begin
            st_d[o]  = st_q[o];
            own_d[o] = own_q[o];
            ptr_d[o] = ptr_q[o];
`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
            cnt_d[o] = cnt_q[o];
`endif
            unique case (st_q[o])
                IDLE: begin
`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
                    cnt_d[o] = '0;
`endif
                    if (found[o]) begin
                        st_d[o]  = LOCKED;
                        own_d[o] = win[o];
                    end
                end
                LOCKED: begin
                    if (xfer[o]) begin
`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
                        cnt_d[o] = '0;
`endif
                        if (tail_v[own_q[o]]) begin
                            st_d[o]  = IDLE;
                            ptr_d[o] = own_q[o];
                        end
                    end else begin
`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
                        if (cnt_q[o] + 1'b1 == HoldMaxC) begin
                            st_d[o]  = IDLE;
                            ptr_d[o] = own_q[o];
                            cnt_d[o] = '0;
                            err_d[o] = 1'b1;
                        end else begin
                            cnt_d[o] = cnt_q[o] + 1'b1;
                        end
`endif
                    end
                end
                default: st_d[o] = IDLE;
            endcase
        end
    end

    // State registers; reset drops any lock immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < 5; o++) begin
                st_q[o]  <= IDLE;
                own_q[o] <= 3'd0;
                ptr_q[o] <= 3'd4;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                st_q[o]  <= st_d[o];
                own_q[o] <= own_d[o];
                ptr_q[o] <= ptr_d[o];
            end
        end
    end

`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
    // Stall counters and the one-cycle forced-release pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < 5; o++) begin
                cnt_q[o] <= '0;
            end
            err_q <= 5'b0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                cnt_q[o] <= cnt_d[o];
            end
            err_q <= err_d;
        end
    end

    assign sw.err_timeout = err_q;
`endif

    assign sw.e_gnt   = gnt[0];
    assign sw.w_gnt   = gnt[1];
    assign sw.n_gnt   = gnt[2];
    assign sw.s_gnt   = gnt[3];
    assign sw.j_gnt   = gnt[4];
    assign sw.sel_e   = sel[0];
    assign sw.sel_w   = sel[1];
    assign sw.sel_n   = sel[2];
    assign sw.sel_s   = sel[3];
    assign sw.sel_j   = sel[4];
    assign sw.alloc_e = xfer[0];
    assign sw.alloc_w = xfer[1];
    assign sw.alloc_n = xfer[2];
    assign sw.alloc_s = xfer[3];
    assign sw.alloc_j = xfer[4];
endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter.
// Timeout section builds only with SWITCH_ARB_HOLD_TIMEOUT_EN.
module tb_switch_arbiter;
`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
    localparam int TbHold = 4;
`else
    localparam int TbHold = 16;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   rr_cnt [5];

    switch_arbiter_if sw_if ();

    switch_arbiter #(
        .HOLD_MAX (TbHold),
        .CNT_W    (5)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sw_if.e_req = 3'b111; sw_if.w_req = 3'b111;
        sw_if.n_req = 3'b111; sw_if.s_req = 3'b111;
        sw_if.j_req = 3'b111;
        sw_if.e_vc_grant = 0; sw_if.w_vc_grant = 0;
        sw_if.n_vc_grant = 0; sw_if.s_vc_grant = 0;
        sw_if.j_vc_grant = 0;
        sw_if.e_tail = 0; sw_if.w_tail = 0; sw_if.n_tail = 0;
        sw_if.s_tail = 0; sw_if.j_tail = 0;
        sw_if.e_credit = 1; sw_if.w_credit = 1;
        sw_if.n_credit = 1; sw_if.s_credit = 1;
        sw_if.j_credit = 1;
    endtask

    function automatic logic [4:0] gnt_vec();
        return {sw_if.j_gnt, sw_if.s_gnt, sw_if.n_gnt,
                sw_if.w_gnt, sw_if.e_gnt};
    endfunction

    function automatic logic [4:0] alloc_vec();
        return {sw_if.alloc_j, sw_if.alloc_s, sw_if.alloc_n,
                sw_if.alloc_w, sw_if.alloc_e};
    endfunction

    initial begin
        logic [4:0] exp_g;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        clear_inputs();

        // Reset state
        #12;
        check("rst_alloc", 32'(alloc_vec()), 32'h0);
        check("rst_gnt", 32'(gnt_vec()), 32'h0);
        check("rst_sel_s", 32'(sw_if.sel_s), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // E and N both to S; E first, then N after a bubble
        sw_if.e_req = 3'b011; sw_if.e_vc_grant = 1; sw_if.e_tail = 1;
        sw_if.n_req = 3'b011; sw_if.n_vc_grant = 1; sw_if.n_tail = 1;
        #1;
        check("s_arb_alloc", 32'(sw_if.alloc_s), 32'h0);
        check("s_arb_gnt", 32'(gnt_vec()), 32'h0);
        step();
        check("s_x1_alloc", 32'(sw_if.alloc_s), 32'h1);
        check("s_x1_sel", 32'(sw_if.sel_s), 32'h0);
        check("s_x1_gnt", 32'(gnt_vec()), 32'h01);
        step();
        check("s_bub_alloc", 32'(sw_if.alloc_s), 32'h0);
        check("s_bub_sel", 32'(sw_if.sel_s), 32'h0);
        step();
        check("s_x2_sel", 32'(sw_if.sel_s), 32'h2);
        check("s_x2_gnt", 32'(gnt_vec()), 32'h04);
        step();
        clear_inputs();
        #1;

        // Three-flit W->J with a 3-cycle credit stall
        sw_if.w_req = 3'b100; sw_if.w_vc_grant = 1;
        #1;
        check("j_arb_alloc", 32'(sw_if.alloc_j), 32'h0);
        step();
        check("j_f1_alloc", 32'(sw_if.alloc_j), 32'h1);
        check("j_f1_gnt", 32'(gnt_vec()), 32'h02);
        step();
        sw_if.j_credit = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("j_stall_alloc", 32'(sw_if.alloc_j), 32'h0);
            check("j_stall_sel", 32'(sw_if.sel_j), 32'h1);
            check("j_stall_gnt", 32'(gnt_vec()), 32'h0);
            step();
        end
        sw_if.j_credit = 1;
        #1;
        check("j_f2_alloc", 32'(sw_if.alloc_j), 32'h1);
        step();
        sw_if.w_tail = 1;
        #1;
        check("j_f3_gnt", 32'(gnt_vec()), 32'h02);
        step();
        clear_inputs();
        #1;
        check("j_idle_alloc", 32'(sw_if.alloc_j), 32'h0);
        check("j_idle_sel", 32'(sw_if.sel_j), 32'h0);
        step();

        // Fairness: everyone to E, single-flit packets
        sw_if.e_req = 3'b000; sw_if.w_req = 3'b000;
        sw_if.n_req = 3'b000; sw_if.s_req = 3'b000;
        sw_if.j_req = 3'b000;
        sw_if.e_vc_grant = 1; sw_if.w_vc_grant = 1;
        sw_if.n_vc_grant = 1; sw_if.s_vc_grant = 1;
        sw_if.j_vc_grant = 1;
        sw_if.e_tail = 1; sw_if.w_tail = 1; sw_if.n_tail = 1;
        sw_if.s_tail = 1; sw_if.j_tail = 1;
        for (int i = 0; i < 5; i++) rr_cnt[i] = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            exp_g = (c % 2 == 1) ? 5'(1 << ((c / 2) % 5)) : 5'b0;
            check("rr_gnt", 32'(gnt_vec()), 32'(exp_g));
            for (int i = 0; i < 5; i++) begin
                if (gnt_vec()[i]) rr_cnt[i]++;
            end
            step();
        end
        for (int i = 0; i < 5; i++) begin
            check("rr_count", rr_cnt[i], 32'd2);
        end
        clear_inputs();
        step();

        // Parallel: five independent transfers at once
        sw_if.e_req = 3'b001; sw_if.w_req = 3'b000;
        sw_if.n_req = 3'b011; sw_if.s_req = 3'b010;
        sw_if.j_req = 3'b100;
        sw_if.e_vc_grant = 1; sw_if.w_vc_grant = 1;
        sw_if.n_vc_grant = 1; sw_if.s_vc_grant = 1;
        sw_if.j_vc_grant = 1;
        sw_if.e_tail = 1; sw_if.w_tail = 1; sw_if.n_tail = 1;
        sw_if.s_tail = 1; sw_if.j_tail = 1;
        #1;
        check("par_arb", 32'(alloc_vec()), 32'h0);
        step();
        check("par_alloc", 32'(alloc_vec()), 32'h1f);
        check("par_gnt", 32'(gnt_vec()), 32'h1f);
        check("par_sels", 32'({sw_if.sel_e, sw_if.sel_w, sw_if.sel_n,
                                sw_if.sel_s, sw_if.sel_j}),
              32'({3'd1, 3'd0, 3'd3, 3'd2, 3'd4}));
        step();
        clear_inputs();
        step();

        // W wins E once so ptr_e moves to W
        sw_if.w_req = 3'b000; sw_if.w_vc_grant = 1; sw_if.w_tail = 1;
        step();
        check("pre_w_gnt", 32'(gnt_vec()), 32'h02);
        step();
        clear_inputs();
        // N locks E with a multi-flit packet, then reset mid-packet
        sw_if.n_req = 3'b000; sw_if.n_vc_grant = 1;
        step();
        check("nlock_sel", 32'(sw_if.sel_e), 32'h2);
        check("nlock_alloc", 32'(sw_if.alloc_e), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("arst_alloc", 32'(alloc_vec()), 32'h0);
        check("arst_gnt", 32'(gnt_vec()), 32'h0);
        check("arst_sel_e", 32'(sw_if.sel_e), 32'h0);
        clear_inputs();
        @(posedge clk);
        #1 reset = 1'b1;
        // ptr back to 4: E beats W and N
        sw_if.e_req = 3'b000; sw_if.e_vc_grant = 1; sw_if.e_tail = 1;
        sw_if.w_req = 3'b000; sw_if.w_vc_grant = 1; sw_if.w_tail = 1;
        sw_if.n_req = 3'b000; sw_if.n_vc_grant = 1; sw_if.n_tail = 1;
        #1;
        check("post_arb", 32'(sw_if.alloc_e), 32'h0);
        step();
        check("post_gnt", 32'(gnt_vec()), 32'h01);
        check("post_sel", 32'(sw_if.sel_e), 32'h0);
        step();
        clear_inputs();
        step();

`ifdef SWITCH_ARB_HOLD_TIMEOUT_EN
        // S->W stalled on credit until forced release
        sw_if.s_req = 3'b001; sw_if.s_vc_grant = 1;
        sw_if.w_credit = 0;
        #1;
        check("to_arb_err", 32'(sw_if.err_timeout), 32'h0);
        step();
        for (int c = 0; c < 4; c++) begin
            check("to_stall_alloc", 32'(sw_if.alloc_w), 32'h0);
            check("to_stall_sel", 32'(sw_if.sel_w), 32'h3);
            check("to_stall_err", 32'(sw_if.err_timeout), 32'h0);
            step();
        end
        check("to_err", 32'(sw_if.err_timeout), 32'h02);
        check("to_idle_sel", 32'(sw_if.sel_w), 32'h0);
        clear_inputs();
        step();
        check("to_err_clr", 32'(sw_if.err_timeout), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
